logic_gate_n: RTL and testbench



---
 rtl/logic_gate_pkg.sv | 27 ++
 rtl/logic_gate_eval.sv | 27 ++
 rtl/logic_gate_n.sv | 123 ++++++++++++
 tb/tb_logic_gate_n.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// rtl/logic_gate_pkg.sv - shared enums and delay-counter width helper for logic_gate_n
package logic_gate_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_NAND = 3'd2,
    MODE_NOR  = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_BUF  = 3'd6,
    MODE_INV  = 3'd7
  } gate_mode_e;

  typedef enum logic [1:0] {
    STABLE    = 2'd0,
    PEND_RISE = 2'd1,
    PEND_FALL = 2'd2
  } gate_state_e;

  function automatic int unsigned dly_cnt_width(input int unsigned rise, input int unsigned fall);
    int unsigned m;
    m = (rise > fall) ? rise : fall;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/logic_gate_eval.sv
// rtl/logic_gate_eval.sv - combinational N-input Boolean function evaluator
module logic_gate_eval
  import logic_gate_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] in,
  input  logic [2:0]   mode,
  output logic         f
);

  always_comb begin
    f = 1'b0;
    case (gate_mode_e'(mode))
      MODE_AND:  f = &in;
      MODE_OR:   f = |in;
      MODE_NAND: f = ~&in;
      MODE_NOR:  f = ~|in;
      MODE_XOR:  f = ^in;
      MODE_XNOR: f = ~^in;
      MODE_BUF:  f = in[0];
      MODE_INV:  f = ~in[0];
      default:   f = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_gate_n.sv
// rtl/logic_gate_n.sv - clocked N-input gate with per-edge inertial delay
// Optional glitch counter enabled by LOGIC_GATE_GLITCH_CNT_EN.
module logic_gate_n
  import logic_gate_pkg::*;
#(
  parameter int       N        = 2,
  parameter int       RISE_DLY = 1,
  parameter int       FALL_DLY = 1,
  parameter bit       INIT     = 1'b0,
  parameter int       GW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in,
  input  logic [2:0]    mode,
  output logic          out,
  output logic          busy,
  output logic          edge_p,
  input  logic          glitch_clr,
  output logic [GW-1:0] glitch_cnt
);

  localparam int unsigned CW = dly_cnt_width(RISE_DLY, FALL_DLY);
  localparam logic [CW-1:0] RISE_C = CW'(RISE_DLY);
  localparam logic [CW-1:0] FALL_C = CW'(FALL_DLY);

  logic          f;
  gate_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          edge_q, edge_d;
  logic          busy_q;
  logic          cancel;

  logic_gate_eval #(.N(N)) u_eval (
    .in   (in),
    .mode (mode),
    .f    (f)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    edge_d  = 1'b0;
    cancel  = 1'b0;
    case (state_q)
      STABLE: begin
        if (f != out_q) begin
          state_d = f ? PEND_RISE : PEND_FALL;
          cnt_d   = CW'(1);
        end
      end
      PEND_RISE, PEND_FALL: begin
        if (f == out_q) begin
          state_d = STABLE;
          cnt_d   = '0;
          cancel  = 1'b1;
        end else if (cnt_q == ((state_q == PEND_RISE) ? RISE_C : FALL_C)) begin
          out_d   = f;
          edge_d  = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= INIT;
      edge_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      edge_q  <= edge_d;
      busy_q  <= (state_d != STABLE);
    end
  end

  assign out    = out_q;
  assign edge_p = edge_q;
  assign busy   = busy_q;

`ifdef LOGIC_GATE_GLITCH_CNT_EN
  logic [GW-1:0] glitch_q, glitch_d;

  // Clear has priority over a same-cycle cancel.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (cancel && (glitch_q != {GW{1'b1}})) begin
      glitch_d = glitch_q + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic glitch_unused;
  assign glitch_unused = glitch_clr ^ cancel;
  assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_logic_gate_n.sv
// tb/tb_logic_gate_n.sv - self-checking bench for logic_gate_n against a run-length reference model
module tb_logic_gate_n;

  localparam int N        = 3;
  localparam int RISE_DLY = 3;
  localparam int FALL_DLY = 2;
  localparam bit INIT     = 1'b0;
  localparam int GW       = 2;
`ifdef LOGIC_GATE_GLITCH_CNT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_s;
  logic [2:0]    mode_s;
  logic          clr_s;
  logic          out;
  logic          busy;
  logic          edge_p;
  logic [GW-1:0] glitch_cnt;

  int tests = 0;
  int fails = 0;

  // Reference: out flips once f has differed from it on D+1 consecutive edges.
  int   run_m;
  logic out_m;
  logic edge_m;
  int   glitch_m;

  always #5 clk = ~clk;

  logic_gate_n #(
    .N(N), .RISE_DLY(RISE_DLY), .FALL_DLY(FALL_DLY), .INIT(INIT), .GW(GW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_s),
    .mode       (mode_s),
    .out        (out),
    .busy       (busy),
    .edge_p     (edge_p),
    .glitch_clr (clr_s),
    .glitch_cnt (glitch_cnt)
  );

  function automatic logic f_ref(input logic [N-1:0] v, input int m);
    int ones;
    ones = $countones(v);
    case (m)
      0: return ones == N;
      1: return ones > 0;
      2: return ones != N;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      6: return v[0];
      default: return !v[0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_m    = 0;
    out_m    = INIT;
    edge_m   = 1'b0;
    glitch_m = 0;
  endtask

  task automatic model_edge();
    logic f;
    int   d;
    f      = f_ref(in_s, int'(mode_s));
    d      = out_m ? FALL_DLY : RISE_DLY;
    edge_m = 1'b0;
    if (f != out_m) begin
      run_m++;
      if (run_m == d + 1) begin
        out_m  = f;
        edge_m = 1'b1;
        run_m  = 0;
      end
    end else begin
      if (run_m > 0 && GLITCH_EN && glitch_m < (1 << GW) - 1) glitch_m++;
      run_m = 0;
    end
    if (clr_s) glitch_m = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"},    32'(out),        32'(out_m));
    chk({tag, "_busy"},   32'(busy),       32'(run_m > 0));
    chk({tag, "_edge"},   32'(edge_p),     32'(edge_m));
    chk({tag, "_glitch"}, 32'(glitch_cnt), 32'(glitch_m));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_out"},    32'(out),        32'(INIT));
    chk({tag, "_rst_busy"},   32'(busy),       32'd0);
    chk({tag, "_rst_edge"},   32'(edge_p),     32'd0);
    chk({tag, "_rst_glitch"}, 32'(glitch_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    in_s   = '0;
    mode_s = 3'd0;
    clr_s  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // AND rise with delay 3
    tick("idle");
    in_s = 3'b111;
    for (int i = 0; i < 3; i++) tick("and_pend");
    chk("and_busy_pending", 32'(busy), 32'd1);
    tick("and_fire");
    chk("and_out_risen", 32'(out), 32'd1);
    chk("and_edge_pulse", 32'(edge_p), 32'd1);
    tick("and_after");
    chk("and_edge_single", 32'(edge_p), 32'd0);

    // back to 0, then a short rise that gets cancelled
    in_s = 3'b000;
    for (int i = 0; i < 3; i++) tick("and_fall");
    chk("and_out_fallen", 32'(out), 32'd0);
    in_s = 3'b111;
    repeat (2) tick("glitch_pend");
    in_s = 3'b011;
    tick("glitch_cancel");
    chk("glitch_out_held", 32'(out), 32'd0);
    chk("glitch_busy_clear", 32'(busy), 32'd0);
    chk("glitch_cnt_one", 32'(glitch_cnt), GLITCH_EN ? 32'd1 : 32'd0);

    // XOR fall interrupted by async reset
    mode_s = 3'd4;
    in_s   = 3'b001;
    for (int i = 0; i < 4; i++) tick("xor_rise");
    chk("xor_out_high", 32'(out), 32'd1);
    in_s = 3'b000;
    tick("xor_fall_pend");
    async_reset("xor");
    for (int i = 0; i < 4; i++) tick("xor_post_rst");
    chk("xor_no_transition", 32'(out), 32'(INIT));

    // BUF -> INV switch while pending rise cancels
    mode_s = 3'd6;
    in_s   = 3'b001;
    tick("buf_pend");
    mode_s = 3'd7;
    tick("inv_cancel");
    chk("mode_switch_glitch", 32'(glitch_cnt), GLITCH_EN ? 32'd1 : 32'd0);
    mode_s = 3'd6;
    tick("buf_pend2");
    in_s  = 3'b000;
    clr_s = 1'b1;
    tick("clr_vs_cancel");
    chk("clr_wins", 32'(glitch_cnt), 32'd0);
    clr_s = 1'b0;

    // saturation with GW=2
    for (int i = 0; i < 5; i++) begin
      in_s = 3'b001;
      tick("sat_hi");
      in_s = 3'b000;
      tick("sat_lo");
    end
    chk("glitch_saturated", 32'(glitch_cnt), GLITCH_EN ? 32'd3 : 32'd0);

    // randomized holds against the reference model
    for (int i = 0; i < 400; i++) begin
      int hold;
      in_s   = N'($urandom);
      mode_s = ($urandom_range(0, 7) == 0) ? 3'($urandom) : mode_s;
      clr_s  = ($urandom_range(0, 15) == 0);
      hold   = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) tick("rand");
      clr_s = 1'b0;
      if ($urandom_range(0, 60) == 0) async_reset("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
